alu_rr_arbiter: RTL and testbench



---
 rtl/alu_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Shares one external combinational ALU between two requesters with a round-robin
// arbiter, valid/ready handshakes on both sides and a completed-operation counter.
module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       winner;

    function automatic logic [1:0] one_hot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Round-robin winner: a lone request wins, a tie goes to the requester not granted last
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = one_hot(~last_grant);
            default: grant = 2'b00;
        endcase
    end

    // Offer the grant only while idle and not being reset
    always_comb begin
        req_ready = 2'b00;
        if ((state == IDLE) && !rst) begin
            req_ready = grant;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign winner = req_ready[1];

    // Operation sequencing: accept, one ALU settle cycle, then hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 2'b00;
            busy       <= 1'b0;
            op_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= winner ? req1_a   : req0_a;
                        alu_b      <= winner ? req1_b   : req0_b;
                        alu_sel    <= winner ? req1_sel : req0_sel;
                        owner      <= winner;
                        last_grant <= winner;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_valid <= one_hot(owner);
                    state     <= RESP;
                end
                RESP: begin
                    // Only the owner's ready retires the response
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        op_count  <= op_count + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [2:0]  req0_sel = 3'd0, req1_sel = 3'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_data, alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        busy;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    // Model: age -1 = no operation held, 0 = just accepted, 1+ = response outstanding
    int          m_age;
    bit          m_own;
    bit          m_lg;
    logic [31:0] m_a, m_b, m_rsp;
    logic [2:0]  m_sel;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    assign alu_result = alu_a + alu_b;

    alu_rr_arbiter #(.WIDTH(32), .SEL_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .busy(busy), .op_count(op_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_age = -1;
        m_own = 1'b0;
        m_lg  = 1'b1;
        m_a   = 32'd0;
        m_b   = 32'd0;
        m_sel = 3'd0;
        m_rsp = 32'd0;
        m_cnt = 16'd0;
    endtask

    function automatic logic [1:0] pick(input logic [1:0] v, input bit lg);
        if (v == 2'b11) return lg ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Called at negedge with inputs driven; checks outputs, advances the model over one edge
    task automatic step();
        logic [1:0] w;
        #1;
        w = (m_age < 0 && !rst) ? pick(req_valid, m_lg) : 2'b00;
        check_eq("req_ready", 32'(req_ready), 32'(w));
        check_eq("rsp_valid", 32'(rsp_valid), (m_age >= 1) ? (m_own ? 32'd2 : 32'd1) : 32'd0);
        check_eq("rsp_data", rsp_data, m_rsp);
        check_eq("busy", 32'(busy), (m_age >= 0) ? 32'd1 : 32'd0);
        check_eq("op_count", 32'(op_count), 32'(m_cnt));
        check_eq("alu_a", alu_a, m_a);
        check_eq("alu_b", alu_b, m_b);
        check_eq("alu_sel", 32'(alu_sel), 32'(m_sel));
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else if (m_age < 0) begin
            if (w != 2'b00) begin
                m_own = w[1];
                m_lg  = w[1];
                m_a   = w[1] ? req1_a : req0_a;
                m_b   = w[1] ? req1_b : req0_b;
                m_sel = w[1] ? req1_sel : req0_sel;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            m_rsp = m_a + m_b;
            m_age = 1;
        end else if (rsp_ready[m_own]) begin
            m_cnt = m_cnt + 16'd1;
            m_age = -1;
        end else begin
            m_age = m_age + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_model();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single request 7+1 from requester 0
        req_valid = 2'b01; req0_a = 32'd7; req0_b = 32'd1; req0_sel = 3'b010;
        rsp_ready = 2'b01;
        steps(3);
        check_eq("single_data", rsp_data, 32'd8);
        req_valid = 2'b00;
        steps(2);
        check_eq("single_cnt", 32'(op_count), 32'd1);

        // Tie from reset: grants alternate 0,1,0,1
        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        req0_a = 32'd5; req0_b = 32'd3; req0_sel = 3'b000;
        req1_a = 32'd9; req1_b = 32'd9; req1_sel = 3'b111;
        steps(12);
        check_eq("tie_cnt", 32'(op_count), 32'd4);

        // Back-pressure: response held while rsp_ready is low, even with both requesting
        do_reset();
        req_valid = 2'b01; req0_a = 32'd2; req0_b = 32'd2; rsp_ready = 2'b00;
        steps(1);
        req_valid = 2'b11;
        steps(7);
        check_eq("bp_data", rsp_data, 32'd4);
        rsp_ready = 2'b01; req_valid = 2'b00;
        steps(2);

        // Wrong-owner ready is ignored
        do_reset();
        req_valid = 2'b10; req1_a = 32'd20; req1_b = 32'd22; req1_sel = 3'b101; rsp_ready = 2'b01;
        steps(1);
        req_valid = 2'b00;
        steps(5);
        check_eq("wrong_owner_pending", 32'(rsp_valid), 32'd2);
        rsp_ready = 2'b10;
        steps(2);

        // Reset during EXEC discards the operation; requester 0 then wins a tie
        req_valid = 2'b01; req0_a = 32'd11; req0_b = 32'd12; rsp_ready = 2'b11;
        steps(1);
        req_valid = 2'b00;
        do_reset();
        check_eq("rst_exec_valid", 32'(rsp_valid), 32'd0);
        req_valid = 2'b11;
        step();
        steps(3);

        // Counter wrap from preloaded 16'hFFFF
        req_valid = 2'b00;
        steps(3);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        m_cnt = 16'hFFFF;
        req_valid = 2'b01; rsp_ready = 2'b01;
        steps(1);
        req_valid = 2'b00;
        steps(3);
        check_eq("wrap", 32'(op_count), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            req0_a = $urandom; req0_b = $urandom; req0_sel = 3'($urandom_range(0, 7));
            req1_a = $urandom; req1_b = $urandom; req1_sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
